sis_digital_param: RTL and testbench

Parametrised accumulator datapath with an instruction handshake.
- Two operand registers A and B load from `dados`.
- An ALU combines A with either B or the accumulator C (feedback select).
- A multi-cycle shifter operates on C.
- A controller FSM sequences each accepted instruction and pulses `fim` on completion.
- It replaces the fixed 4-bit controller/register/ULA/deslocamento top as the lab's reusable compute core.

---
 rtl/sis_digital_pkg.sv | 29 ++
 rtl/ula_param.sv | 58 +++++
 rtl/sis_digital_param.sv | 156 +++++++++++++++
 tb/tb_sis_digital_param.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sis_digital_pkg.sv
// Shared opcodes, controller state codes and sizing helper for the sis_digital compute core.
package sis_digital_pkg;

    localparam logic [2:0] OP_LDA = 3'd0;
    localparam logic [2:0] OP_LDB = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3
    } state_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((32'sd1 << res) < value) begin
            res = res + 32'sd1;
        end
        return (res < 32'sd1) ? 32'sd1 : res;
    endfunction

endpackage

// File: rtl/ula_param.sv
// Combinational ADD/SUB/AND/OR unit with carry/borrow out.
// Build macro SATURATE_EN: ADD clamps to all-ones on overflow, SUB clamps to zero on borrow.
module ula_param
    import sis_digital_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             co
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;

    // Result and carry selection; the extra MSB of the difference is the borrow.
    always_comb begin
        sum_s  = {1'b0, a} + {1'b0, b};
        diff_s = {1'b0, a} - {1'b0, b};
        y      = '0;
        co     = 1'b0;
        case (op)
            OP_ADD: begin
                co = sum_s[WIDTH];
`ifdef SATURATE_EN
                if (sum_s[WIDTH]) begin
                    y = '1;
                end else begin
                    y = sum_s[WIDTH-1:0];
                end
`else
                y = sum_s[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                co = diff_s[WIDTH];
`ifdef SATURATE_EN
                if (diff_s[WIDTH]) begin
                    y = '0;
                end else begin
                    y = diff_s[WIDTH-1:0];
                end
`else
                y = diff_s[WIDTH-1:0];
`endif
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            default: begin
                y  = '0;
                co = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sis_digital_param.sv
// Parametrised accumulator core: A/B operand registers, ALU into accumulator C,
// multi-cycle shifter on C, and an instruction-handshake controller. Build macro SATURATE_EN (see ula_param).
module sis_digital_param
    import sis_digital_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GUARD = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [2:0]             instr_op,
    input  logic                   instr_sel,
    input  logic [WIDTH-1:0]       dados,
    output logic [WIDTH+GUARD-1:0] reg_a,
    output logic [WIDTH+GUARD-1:0] reg_b,
    output logic [WIDTH+GUARD-1:0] reg_c,
    output logic                   carry,
    output logic                   zero,
    output logic                   fim,
    output logic [2:0]             estado
);

    localparam int ACC_W = WIDTH + GUARD;
    localparam int CNT_W = clog2(ACC_W + 1);
    localparam logic [ACC_W-1:0] ACC_W_V = ACC_W'(ACC_W);

    state_t             state_r;
    state_t             state_nx_s;
    logic [2:0]         op_r;
    logic               sel_r;
    logic [WIDTH-1:0]   dados_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [ACC_W-1:0]   c_r;
    logic               carry_r;
    logic               zero_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               accept_s;
    logic               is_shift_s;
    logic [ACC_W-1:0]   dados_ext_s;
    logic [CNT_W-1:0]   cnt_load_s;
    logic [ACC_W-1:0]   opnd_s;
    logic [ACC_W-1:0]   alu_y_s;
    logic               alu_co_s;
    logic [ACC_W-1:0]   shift_c_s;

    assign accept_s    = instr_valid && (state_r == ST_IDLE);
    assign is_shift_s  = (op_r == OP_SHL) || (op_r == OP_SHR);
    assign dados_ext_s = ACC_W'(dados_r);
    // Amounts of ACC_W or more are capped: ACC_W single-bit steps already clear C.
    assign cnt_load_s  = (dados_ext_s >= ACC_W_V) ? CNT_W'(ACC_W) : CNT_W'(dados_ext_s);
    assign opnd_s      = sel_r ? c_r : ACC_W'(b_r);
    assign shift_c_s   = (op_r == OP_SHL) ? (c_r << 1'b1) : (c_r >> 1'b1);

    ula_param #(.WIDTH(ACC_W)) u_ula (
        .a  (ACC_W'(a_r)),
        .b  (opnd_s),
        .op (op_r),
        .y  (alu_y_s),
        .co (alu_co_s)
    );

    // Controller next-state decode; unused codes fall back to IDLE.
    always_comb begin
        state_nx_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_EXEC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (is_shift_s && (cnt_load_s != CNT_W'(0))) begin
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, instruction capture and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            op_r    <= 3'd0;
            sel_r   <= 1'b0;
            dados_r <= '0;
            a_r     <= '0;
            b_r     <= '0;
            c_r     <= '0;
            carry_r <= 1'b0;
            zero_r  <= 1'b1;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r    <= instr_op;
                        sel_r   <= instr_sel;
                        dados_r <= dados;
                    end
                end
                ST_EXEC: begin
                    case (op_r)
                        OP_LDA: a_r <= dados_r;
                        OP_LDB: b_r <= dados_r;
                        OP_SHL, OP_SHR: begin
                            carry_r <= 1'b0;
                            cnt_r   <= cnt_load_s;
                            zero_r  <= (c_r == '0);
                        end
                        default: begin
                            c_r     <= alu_y_s;
                            carry_r <= alu_co_s;
                            zero_r  <= (alu_y_s == '0);
                        end
                    endcase
                end
                ST_SHIFT: begin
                    c_r    <= shift_c_s;
                    zero_r <= (shift_c_s == '0);
                    cnt_r  <= cnt_r - CNT_W'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign instr_ready = (state_r == ST_IDLE);
    assign fim         = (state_r == ST_DONE);
    assign estado      = state_r;
    assign reg_a       = ACC_W'(a_r);
    assign reg_b       = ACC_W'(b_r);
    assign reg_c       = c_r;
    assign carry       = carry_r;
    assign zero        = zero_r;

endmodule

// File: tb/tb_sis_digital_param.sv
// Self-checking bench for sis_digital_param (WIDTH=4, GUARD=2): reference model feeds a scoreboard queue.
module tb_sis_digital_param;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic       instr_sel;
    logic [3:0] dados;
    logic [5:0] reg_a;
    logic [5:0] reg_b;
    logic [5:0] reg_c;
    logic       carry;
    logic       zero;
    logic       fim;
    logic [2:0] estado;

    typedef struct packed {
        logic [5:0]  c;
        logic        carry;
        logic        zero;
        logic [5:0]  a;
        logic [5:0]  b;
        logic [7:0]  lat;
        logic [7:0]  busy;
        logic [29:0] est;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp;
    int   n_err;
    int   m_a, m_b, m_c;
    logic m_carry, m_zero;

    sis_digital_param #(.WIDTH(4), .GUARD(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_sel   (instr_sel),
        .dados       (dados),
        .reg_a       (reg_a),
        .reg_b       (reg_b),
        .reg_c       (reg_c),
        .carry       (carry),
        .zero        (zero),
        .fim         (fim),
        .estado      (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_a = 0; m_b = 0; m_c = 0; m_carry = 1'b0; m_zero = 1'b1;
    endtask

    // ins = {op[2:0], sel, dados[3:0]}
    task automatic model_push(input logic [7:0] ins);
        int op, sel, d, opnd, n, s, idx;
        obs_t e;
        op = int'(ins[7:5]); sel = int'(ins[4]); d = int'(ins[3:0]);
        opnd = (sel != 0) ? m_c : m_b;
        n = 0;
        e = '0;
        case (op)
            0: m_a = d;
            1: m_b = d;
            2: begin
                s = m_a + opnd;
                m_carry = (s > 63);
`ifdef SATURATE_EN
                m_c = m_carry ? 63 : s;
`else
                m_c = s % 64;
`endif
                m_zero = (m_c == 0);
            end
            3: begin
                m_carry = (m_a < opnd);
`ifdef SATURATE_EN
                m_c = m_carry ? 0 : m_a - opnd;
`else
                m_c = (m_a - opnd + 64) % 64;
`endif
                m_zero = (m_c == 0);
            end
            4: begin m_c = m_a & opnd; m_carry = 1'b0; m_zero = (m_c == 0); end
            5: begin m_c = m_a | opnd; m_carry = 1'b0; m_zero = (m_c == 0); end
            6: begin n = (d > 6) ? 6 : d; m_c = (m_c << n) & 63; m_carry = 1'b0; m_zero = (m_c == 0); end
            default: begin n = (d > 6) ? 6 : d; m_c = m_c >> n; m_carry = 1'b0; m_zero = (m_c == 0); end
        endcase
        e.c = 6'(m_c); e.carry = m_carry; e.zero = m_zero; e.a = 6'(m_a); e.b = 6'(m_b);
        e.lat = 8'(n + 2);
        e.busy = e.lat;
        e.est[2:0] = 3'd1;
        idx = 1;
        for (int j = 0; j < n; j++) begin
            e.est[3*idx +: 3] = 3'd2;
            idx++;
        end
        e.est[3*idx +: 3] = 3'd3;
        exp_q.push_back(e);
    endtask

    task automatic run_instr(input logic [7:0] ins, output obs_t o);
        int k, g;
        logic fim_seen;
        o = '0;
        o.lat = 8'hFF;
        fim_seen = 1'b0;
        @(negedge clk);
        instr_valid = 1'b1; instr_op = ins[7:5]; instr_sel = ins[4]; dados = ins[3:0];
        g = 0;
        while (!instr_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        dados = ~ins[3:0];
        k = 0;
        while (k < 40) begin
            if (k < 10) o.est[3*k +: 3] = estado;
            if (instr_ready) break;
            if (fim && !fim_seen) begin
                fim_seen = 1'b1;
                o.lat = 8'(k + 1);
                o.c = reg_c; o.carry = carry; o.zero = zero; o.a = reg_a; o.b = reg_b;
            end
            @(negedge clk);
            k++;
        end
        o.busy = 8'(k);
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b0; instr_op = 3'd0; instr_sel = 1'b0; dados = 4'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({reg_a, reg_b, reg_c, carry, zero, fim, estado, instr_ready} !== {6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset: got a=%0d b=%0d c=%0d carry=%b zero=%b fim=%b estado=%0d ready=%b, required 0 0 0 0 1 0 0 1",
                     reg_a, reg_b, reg_c, carry, zero, fim, estado, instr_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alu();
        logic [7:0] prog [15] = '{8'b000_0_1001, 8'b001_0_0101, 8'b010_0_0000,
                                  8'b000_0_0101, 8'b001_0_1001, 8'b011_0_0000,
                                  8'b000_0_1001, 8'b001_0_0101, 8'b010_0_0000, 8'b010_1_0000,
                                  8'b000_0_1111, 8'b001_0_0000, 8'b010_0_0000, 8'b110_0_0010,
                                  8'b010_1_0000};
        obs_t o, e;
        for (int i = 0; i < 15; i++) begin
            model_push(prog[i]);
            run_instr(prog[i], o);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL alu[%0d]: got c=%0d carry=%b zero=%b a=%0d b=%0d fim_edge=%0d busy=%0d est=%h, required c=%0d carry=%b zero=%b a=%0d b=%0d fim_edge=%0d busy=%0d est=%h",
                         i, o.c, o.carry, o.zero, o.a, o.b, o.lat, o.busy, o.est, e.c, e.carry, e.zero, e.a, e.b, e.lat, e.busy, e.est);
            end
        end
    endtask

    task automatic test_shift_logic();
        logic [7:0] prog [9] = '{8'b000_0_0011, 8'b001_0_0000, 8'b010_0_0000,
                                 8'b110_0_0010, 8'b111_0_1111, 8'b101_0_0000,
                                 8'b110_0_0000, 8'b111_0_0011, 8'b100_1_0000};
        obs_t o, e;
        for (int i = 0; i < 9; i++) begin
            model_push(prog[i]);
            run_instr(prog[i], o);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL shift[%0d]: got c=%0d carry=%b zero=%b a=%0d b=%0d fim_edge=%0d busy=%0d est=%h, required c=%0d carry=%b zero=%b a=%0d b=%0d fim_edge=%0d busy=%0d est=%h",
                         i, o.c, o.carry, o.zero, o.a, o.b, o.lat, o.busy, o.est, e.c, e.carry, e.zero, e.a, e.b, e.lat, e.busy, e.est);
            end
        end
    endtask

    task automatic test_back_to_back();
        int q[$];
        int acc, fims, ea;
        acc = 0; fims = 0;
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 3'd0; instr_sel = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            dados = 4'(i + 1);
            if (fim) begin
                fims++;
                ea = (q.size() > 0) ? q.pop_front() : -1;
                n_cmp++;
                if (reg_a !== 6'(ea) || ea < 0) begin
                    n_err++;
                    $display("FAIL b2b_value: got a=%0d, required %0d", reg_a, ea);
                end
            end
            if (instr_ready) begin
                q.push_back(i + 1);
                acc++;
            end
        end
        instr_valid = 1'b0;
        n_cmp++;
        if (acc !== 3 || fims !== 3) begin
            n_err++;
            $display("FAIL b2b_count: got accepts=%0d fims=%0d, required 3 and 3", acc, fims);
        end
        m_a = 7;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [7:0] pre [3] = '{8'b000_0_0011, 8'b001_0_0000, 8'b010_0_0000};
        logic [7:0] post [3] = '{8'b000_0_0110, 8'b010_0_0000, 8'b111_0_0001};
        obs_t o, e;
        logic fim_seen;
        for (int i = 0; i < 3; i++) begin
            model_push(pre[i]);
            run_instr(pre[i], o);
            e = exp_q.pop_front();
        end
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 3'd6; instr_sel = 1'b0; dados = 4'd5;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (estado !== 3'd2 || reg_c !== 6'd6) begin
            n_err++;
            $display("FAIL midshift: got estado=%0d c=%0d, required 2 and 6", estado, reg_c);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({reg_a, reg_b, reg_c, zero, estado, instr_ready, fim} !== {6'd0, 6'd0, 6'd0, 1'b1, 3'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL abort_reset: got a=%0d b=%0d c=%0d zero=%b estado=%0d ready=%b fim=%b, required 0 0 0 1 0 1 0",
                     reg_a, reg_b, reg_c, zero, estado, instr_ready, fim);
        end
        fim_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fim) fim_seen = 1'b1;
            if (i == 2) rst = 1'b0;
        end
        n_cmp++;
        if (fim_seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_fim: got fim pulse=%b, required 0", fim_seen);
        end
        model_reset();
        for (int i = 0; i < 3; i++) begin
            model_push(post[i]);
            run_instr(post[i], o);
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL after_reset[%0d]: got c=%0d carry=%b zero=%b a=%0d fim_edge=%0d busy=%0d est=%h, required c=%0d carry=%b zero=%b a=%0d fim_edge=%0d busy=%0d est=%h",
                         i, o.c, o.carry, o.zero, o.a, o.lat, o.busy, o.est, e.c, e.carry, e.zero, e.a, e.lat, e.busy, e.est);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_alu();
        test_shift_logic();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
